// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter for the shared CHIP-8 memory,
// with a boot lock that reserves the memory for the loader port.
// Ports: req/we/addr/wdata per requester in, ack per requester out,
// rdata back to readers, mem_* to the memory, last_grant for debug.
module mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 8,
  parameter int NP = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NP-1:0]    req,
  input  logic [NP-1:0]    we,
  input  logic [NP*AW-1:0] addr,
  input  logic [NP*DW-1:0] wdata,
  input  logic             boot_lock,
  output logic [NP-1:0]    ack,
  output logic [DW-1:0]    rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic [1:0]       last_grant
);

  logic [NP-1:0] ack_q, ack_d;
  logic          rd_q, rd_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    last_grant_q, last_grant_d;

  logic [NP-1:0] elig;
  logic [1:0]    s0, s1, s2;
  logic [1:0]    gnt;
  logic          gnt_vld;

  always_comb begin
    // A port in its ack cycle is masked so a held req is not served twice.
    elig = req & ~ack_q;
    if (boot_lock) elig = elig & 3'b100;

    unique case (last_grant_q)
      2'd0:    s0 = 2'd1;
      2'd1:    s0 = 2'd2;
      default: s0 = 2'd0;
    endcase
    s1 = (s0 == 2'd2) ? 2'd0 : s0 + 2'd1;
    s2 = (s1 == 2'd2) ? 2'd0 : s1 + 2'd1;

    gnt     = 2'd0;
    gnt_vld = 1'b0;
    if (elig[s0]) begin
      gnt     = s0;
      gnt_vld = 1'b1;
    end else if (elig[s1]) begin
      gnt     = s1;
      gnt_vld = 1'b1;
    end else if (elig[s2]) begin
      gnt     = s2;
      gnt_vld = 1'b1;
    end
    // Memory strobes stay quiet while reset is held.
    if (!rst_n) gnt_vld = 1'b0;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_vld) begin
      mem_en    = 1'b1;
      mem_we    = we[gnt];
      mem_addr  = addr[gnt*AW +: AW];
      mem_wdata = wdata[gnt*DW +: DW];
    end
  end

  always_comb begin
    ack_d        = '0;
    rd_d         = 1'b0;
    last_grant_d = last_grant_q;
    rdata_d      = rd_q ? mem_rdata : rdata_q;
    if (gnt_vld) begin
      ack_d[gnt]   = 1'b1;
      rd_d         = ~we[gnt];
      last_grant_d = gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q        <= '0;
      rd_q         <= 1'b0;
      rdata_q      <= '0;
      last_grant_q <= 2'd2;
    end else begin
      ack_q        <= ack_d;
      rd_q         <= rd_d;
      rdata_q      <= rdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Read data passes straight through in the ack cycle, then is held.
  assign ack        = ack_q;
  assign rdata      = rd_q ? mem_rdata : rdata_q;
  assign last_grant = last_grant_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single 4 KiB CHIP-8 memory between three requesters:
- port 0: CPU fetch/stack/load-store port
- port 1: sprite/display engine
- port 2: boot loader that writes the program image

Grants at most one access per cycle using round-robin. Returns an ack (plus read data for reads) one cycle after the grant, which matches the req/ack handshake the CPU already uses. A boot lock gives port 2 exclusive access while the image loads.

Parameters:
AW, 12, memory address width
DW, 8, memory data width
NP, 3, number of requester ports (fixed at 3 for this design; port 2 is the lockable boot port)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NP  per-port access request, held until ack
we  input  NP  per-port write enable (1 = write, 0 = read), valid with req
addr  input  NP*AW  packed per-port addresses, port i at [i*AW +: AW]
wdata  input  NP*DW  packed per-port write data
boot_lock  input  1  when 1, only port 2 may be granted
ack  output  NP  one-cycle pulse per port, completion of that port's access
rdata  output  DW  read data, valid in the cycle ack of a read port is high
mem_en  output  1  memory access strobe (combinational)
mem_we  output  1  memory write strobe (combinational)
mem_addr  output  AW  memory address (combinational)
mem_wdata  output  DW  memory write data (combinational)
mem_rdata  input  DW  memory read data, registered by memory, valid one cycle after mem_en&&!mem_we
last_grant  output  2  index of the most recently granted port (debug)

Behaviour:
- Reset (async, rst_n=0):
  - ack=0, rdata=0, last_grant=2 (so port 0 has top priority first), internal pending-ack state cleared.
  - mem_en/mem_we are 0 while in reset.
- Eligibility in cycle T: port i is eligible if req[i]=1 and ack[i]=0 in T. A port being acked this cycle is masked, so a req still held high in its ack cycle is not served twice.
- boot_lock=1: only port 2 is eligible; ports 0/1 wait and are never acked.
- Round-robin: search order starts at last_grant+1 (mod 3). The first eligible port wins.
- Grant cycle T, combinational:
  - mem_en=1, mem_we=we[g], mem_addr=addr[g], mem_wdata=wdata[g].
  - No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Registered at the edge ending T: last_grant<=g, ack[g]<=1 for exactly one cycle (T+1); all other ack bits 0.
- Read: rdata in T+1 equals mem_rdata (pass-through of memory output, qualified by the ack). Write: ack in T+1 only confirms completion; rdata holds its previous value.
- Latency: 1 cycle from grant to ack. Throughput is 1 access/cycle overall. A single port is limited to 1 access per 2 cycles because it is masked during its ack cycle.
- Requester rules: addr/we/wdata stay stable while req=1 and no ack. A requester may deassert req in its ack cycle or re-request from T+2.
- Simultaneous write then read to the same address (different ports, consecutive grants): the read returns the new data. The memory write completes at the edge ending the write's grant cycle.
- boot_lock rising while port 0/1 has an ack pending in the next cycle: that ack still completes. The lock blocks only new grants.
- Reset mid-operation: a pending ack is dropped and never issued. Requesters must re-request after reset.
- Width rules: addresses pass through unmodified (AW bits, no wrap logic here). There is no arithmetic on data.

Test Plan:
- Single read: mem[0x100]=0xA2, req[0]=1 we=0 addr0=0x100 -> mem_en=1 mem_addr=0x100 in T; ack=3'b001, rdata=0xA2 in T+1; last_grant=0.
- All three read-request together continuously, from reset -> grant order 0,1,2,0,1,2...; ack pattern 001,010,100,001 on consecutive cycles; no port acked twice in a row.
- Write then read: port 2 writes 0x5C to 0x200, then port 0 reads 0x200 -> port 0 ack with rdata=0x5C.
- Boot lock: boot_lock=1, req=3'b111 with port 2 streaming writes to 0x200..0x20F -> only ack[2] pulses (every other cycle). Drop boot_lock -> port 0 is granted on the next cycle it is eligible.
- Held req: port 1 holds req high for 6 cycles, alone -> acks in cycles 2, 4, 6 only; mem_en high only in the grant cycles.
- Reset mid-op: grant port 0 read in T, assert rst_n=0 before T+1 edge -> ack stays 0 and rdata=0. After release, port 0 is granted first (last_grant=2).
